aes_v2_issue: RTL and testbench
===============================

AES_V2_ISSUE -- requirements
Module: aes_v2_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum number of cycles in BUSY before the operation is aborted (range 1..255).
REQ-002 SHALL have port g_clk, input, 1: the single clock.
REQ-003 SHALL have port g_resetn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1: core presents an AES operation.
REQ-005 SHALL have port req_ready, output, 1: issue stage accepts the request.
REQ-006 SHALL have port req_op, input, 3: {sub, enc, rot}.
REQ-007 SHALL have ports req_rs1 and req_rs2, input, 32 each: source operands.
REQ-008 SHALL have ports aes_valid, aes_sub, aes_enc, aes_rot (output, 1 each) and aes_rs1, aes_rs2 (output, 32 each): drive to the downstream AES sub/mix unit.
REQ-009 SHALL have port aes_ready, input, 1: downstream unit has completed.
REQ-010 SHALL have port aes_rd, input, 32: downstream result.
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rd (output, 32) and rsp_err (output, 1): result channel to the core.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-013 SHALL drive req_ready=1 only in IDLE; a request is accepted on the clock edge where req_valid and req_ready are both 1.
REQ-014 SHALL, on acceptance, register req_op, req_rs1 and req_rs2 and enter BUSY; aes_valid=1 from the next cycle.
REQ-015 SHALL hold aes_valid, aes_sub/enc/rot and aes_rs1/rs2 stable throughout BUSY; aes_valid=0 in IDLE and RESP.
REQ-016 SHALL, when aes_ready=1 is sampled in BUSY, register aes_rd into rsp_rd, set rsp_err=0 and enter RESP; this edge is also the edge on which aes_valid drops.
REQ-017 SHALL set a minimum latency of 2 cycles from request acceptance to rsp_valid when the downstream unit completes in 1 cycle.
REQ-018 SHALL drive rsp_valid=1 only in RESP and hold rsp_rd and rsp_err stable there until rsp_ready=1 is sampled, then return to IDLE.
REQ-019 SHALL NOT accept a new request in the cycle the response retires; req_ready rises the following cycle.
REQ-020 SHALL use an 8-bit busy counter, cleared on entry to BUSY and incremented each BUSY cycle.
REQ-021 SHALL, if the count reaches TIMEOUT with aes_ready=0, enter RESP with rsp_rd=0 and rsp_err=1.
REQ-022 SHALL give aes_ready priority over timeout when both occur in the same cycle (normal result, rsp_err=0).
REQ-023 SHALL ignore aes_ready outside BUSY.
REQ-024 SHALL ignore req_valid outside IDLE, with no side effects.

Reset
REQ-025 SHALL, on g_resetn=0 (asynchronous, including mid-operation), force state IDLE, counter 0 and all registered outputs to 0: aes_valid, aes_sub/enc/rot, aes_rs1/rs2, rsp_valid, rsp_rd, rsp_err.
REQ-026 SHALL drive req_ready=1 in the first cycle after reset release.

Configuration
REQ-027 SHALL, with AES_V2_ISSUE_DEC_EN defined, forward decrypt operations (enc=0) downstream like any other operation.
REQ-028 SHALL, without AES_V2_ISSUE_DEC_EN, move a decrypt request directly from IDLE to RESP with rsp_rd=0 and rsp_err=1, never asserting aes_valid.

Structure
REQ-029 SHALL place the state enum (IDLE/BUSY/RESP), the req_op bit positions and the TIMEOUT default in the shared package aes_v2_pkg.
REQ-030 SHALL need no sub-module for this block; it instantiates nothing, and aes_v2_size is connected alongside it at the next level up.

Verification
REQ-031 SHALL cover a single encrypt: req_op=3'b110, rs1=32'h00112233, downstream ready after 1 cycle with aes_rd=32'hDEADBEEF -> rsp_valid 2 cycles after acceptance, rsp_rd=32'hDEADBEEF, rsp_err=0.
REQ-032 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rd stable, req_ready=0 throughout.
REQ-033 SHALL cover timeout: aes_ready held 0 with TIMEOUT=15 -> rsp_err=1 and rsp_rd=0 after 15 BUSY cycles.
REQ-034 SHALL cover the tie: aes_ready=1 in the same cycle the count reaches TIMEOUT -> normal result with rsp_err=0.
REQ-035 SHALL cover mid-BUSY reset: g_resetn=0 -> aes_valid=0 immediately, req_ready=1 after release.
REQ-036 SHALL cover a decrypt request (req_op=3'b100) in both builds: with the macro, forwarded downstream; without it, rsp_err=1 and aes_valid never asserted.

Source files
------------

// File: rtl/aes_v2_pkg.sv
// Shared types and constants for the AES issue stage.
// State encoding, req_op bit layout and default busy timeout.
package aes_v2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int OP_SUB = 2;
  localparam int OP_ENC = 1;
  localparam int OP_ROT = 0;

  localparam int TIMEOUT_DEF = 15;

  typedef struct packed {
    logic sub;
    logic enc;
    logic rot;
  } aes_op_t;

endpackage

// File: rtl/aes_v2_issue_if.sv
// Request, downstream and response signals of the AES issue stage.
// master = core/downstream side, slave = issue stage side.
interface aes_v2_issue_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;

  logic        aes_valid;
  logic        aes_sub;
  logic        aes_enc;
  logic        aes_rot;
  logic [31:0] aes_rs1;
  logic [31:0] aes_rs2;
  logic        aes_ready;
  logic [31:0] aes_rd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2,
    input  req_ready,
    input  aes_valid, aes_sub, aes_enc, aes_rot,
    input  aes_rs1, aes_rs2,
    output aes_ready, aes_rd,
    input  rsp_valid, rsp_rd, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2,
    output req_ready,
    output aes_valid, aes_sub, aes_enc, aes_rot,
    output aes_rs1, aes_rs2,
    input  aes_ready, aes_rd,
    output rsp_valid, rsp_rd, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/aes_v2_issue.sv
// AES issue stage: IDLE -> BUSY -> RESP with busy timeout.
// Define AES_V2_ISSUE_DEC_EN to forward decrypt ops downstream.
module aes_v2_issue
  import aes_v2_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        aes_valid,
  output logic        aes_sub,
  output logic        aes_enc,
  output logic        aes_rot,
  output logic [31:0] aes_rs1,
  output logic [31:0] aes_rs2,
  input  logic        aes_ready,
  input  logic [31:0] aes_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  aes_op_t     op_q, op_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic        dec_stop;

`ifdef AES_V2_ISSUE_DEC_EN
  assign dec_stop = 1'b0;
`else
  // decrypt is unsupported here: answer with an error, skip downstream
  assign dec_stop = ~req_op[OP_ENC];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_stop) begin
            state_d = RESP;
            rd_d    = '0;
            err_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            op_d    = aes_op_t'(req_op);
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (aes_ready) begin
          state_d = RESP;
          rd_d    = aes_rd;
          err_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          rd_d    = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign aes_valid = (state_q == BUSY);
  assign rsp_valid = (state_q == RESP);
  assign aes_sub   = op_q.sub;
  assign aes_enc   = op_q.enc;
  assign aes_rot   = op_q.rot;
  assign aes_rs1   = rs1_q;
  assign aes_rs2   = rs2_q;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_aes_v2_issue.sv
// Directed bench for aes_v2_issue: vector table plus reset sequences.
// Decrypt expectations follow AES_V2_ISSUE_DEC_EN.
module tb_aes_v2_issue;
  import aes_v2_pkg::*;

  localparam int TO = TIMEOUT_DEF;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b1;

  aes_v2_issue_if bus();

  aes_v2_issue #(.TIMEOUT(TO)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (bus.req_valid),
    .req_ready (bus.req_ready),
    .req_op    (bus.req_op),
    .req_rs1   (bus.req_rs1),
    .req_rs2   (bus.req_rs2),
    .aes_valid (bus.aes_valid),
    .aes_sub   (bus.aes_sub),
    .aes_enc   (bus.aes_enc),
    .aes_rot   (bus.aes_rot),
    .aes_rs1   (bus.aes_rs1),
    .aes_rs2   (bus.aes_rs2),
    .aes_ready (bus.aes_ready),
    .aes_rd    (bus.aes_rd),
    .rsp_valid (bus.rsp_valid),
    .rsp_ready (bus.rsp_ready),
    .rsp_rd    (bus.rsp_rd),
    .rsp_err   (bus.rsp_err)
  );

  always #5 g_clk = ~g_clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] ard;
    int          delay;
    int          hold;
    bit          fwd;
    int          lat;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("v%0d req_ready", idx), bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_rs1   = v.rs1;
    bus.req_rs2   = v.rs2;
    tick();
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_rs1   = $urandom;
    bus.req_rs2   = $urandom;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      check($sformatf("v%0d busy bundle c%0d", idx, n),
            {bus.aes_valid, bus.aes_sub, bus.aes_enc, bus.aes_rot,
             bus.aes_rs1, bus.aes_rs2},
            {1'b1, v.op, v.rs1, v.rs2});
      n++;
      if (n == v.delay) begin
        bus.aes_ready = 1'b1;
        bus.aes_rd    = v.ard;
      end
      tick();
      bus.aes_ready = 1'b0;
      bus.aes_rd    = $urandom;
    end
    check($sformatf("v%0d busy cycles", idx), n, v.lat);
    check($sformatf("v%0d resp", idx),
          {bus.aes_valid, bus.rsp_valid, bus.rsp_rd, bus.rsp_err},
          {1'b0, 1'b1, v.rd, v.err});
    for (int h = 0; h < v.hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b111;
      bus.aes_ready = 1'b1;
      tick();
      check($sformatf("v%0d hold %0d", idx, h),
            {bus.req_ready, bus.aes_valid, bus.rsp_valid,
             bus.rsp_rd, bus.rsp_err},
            {1'b0, 1'b0, 1'b1, v.rd, v.err});
    end
    bus.aes_ready = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check($sformatf("v%0d retire", idx),
          {bus.req_ready, bus.rsp_valid, bus.aes_valid},
          {1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    vecs[0] = '{3'b110, 32'h00112233, 32'h44556677, 32'hDEADBEEF,
                1, 0, 1'b1, 1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{3'b111, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567,
                3, 5, 1'b1, 3, 32'h01234567, 1'b0};
    vecs[2] = '{3'b010, 32'h0000FFFF, 32'hFFFF0000, 32'h89ABCDEF,
                2, 1, 1'b1, 2, 32'h89ABCDEF, 1'b0};
    vecs[3] = '{3'b011, 32'h11111111, 32'h22222222, 32'h33333333,
                0, 2, 1'b1, TO, 32'h0, 1'b1};
    vecs[4] = '{3'b110, 32'h76543210, 32'hFEDCBA98, 32'hCAFEF00D,
                TO, 0, 1'b1, TO, 32'hCAFEF00D, 1'b0};
`ifdef AES_V2_ISSUE_DEC_EN
    vecs[5] = '{3'b100, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0,
                2, 1, 1'b1, 2, 32'h2468ACE0, 1'b0};
    vecs[6] = '{3'b001, 32'hC0FFEE00, 32'h00C0FFEE, 32'h55AA55AA,
                1, 0, 1'b1, 1, 32'h55AA55AA, 1'b0};
`else
    vecs[5] = '{3'b100, 32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0,
                2, 1, 1'b0, 0, 32'h0, 1'b1};
    vecs[6] = '{3'b001, 32'hC0FFEE00, 32'h00C0FFEE, 32'h55AA55AA,
                1, 0, 1'b0, 0, 32'h0, 1'b1};
`endif

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.aes_ready = 1'b0;
    bus.aes_rd    = '0;
    bus.rsp_ready = 1'b0;

    #1 g_resetn = 1'b0;
    #2;
    check("reset outputs",
          {bus.aes_valid, bus.aes_sub, bus.aes_enc, bus.aes_rot,
           bus.aes_rs1, bus.aes_rs2, bus.rsp_valid, bus.rsp_rd,
           bus.rsp_err},
          '0);
    tick();
    tick();
    @(negedge g_clk);
    g_resetn = 1'b1;
    tick();
    check("req_ready after reset", bus.req_ready, 1);

    bus.aes_ready = 1'b1;
    bus.aes_rd    = 32'hFFFFFFFF;
    tick();
    bus.aes_ready = 1'b0;
    check("aes_ready ignored in idle",
          {bus.req_ready, bus.rsp_valid, bus.aes_valid, bus.rsp_rd},
          {1'b1, 1'b0, 1'b0, 32'h0});

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    bus.req_valid = 1'b1;
    bus.req_op    = 3'b110;
    bus.req_rs1   = 32'h12345678;
    bus.req_rs2   = 32'h9ABCDEF0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("pre-reset busy", {bus.aes_valid, bus.aes_rs1},
          {1'b1, 32'h12345678});
    #2 g_resetn = 1'b0;
    #1;
    check("mid-busy reset",
          {bus.aes_valid, bus.aes_rs1, bus.aes_sub, bus.rsp_valid,
           bus.req_ready},
          {1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    @(negedge g_clk);
    g_resetn = 1'b1;
    tick();
    check("post-reset idle",
          {bus.req_ready, bus.aes_valid, bus.rsp_valid},
          {1'b1, 1'b0, 1'b0});

    run_vec(7, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
